// File: rtl/int_pkg.sv
// Shared constants, state encoding and vector helper for the 8051 interrupt arbiter.
package int_pkg;

    localparam int unsigned N_SRC_DEF      = 5;
    localparam int unsigned SRC_IE0        = 0;
    localparam int unsigned SRC_TF0        = 1;
    localparam int unsigned SRC_IE1        = 2;
    localparam int unsigned SRC_TF1        = 3;
    localparam int unsigned SRC_SER        = 4;
    localparam int unsigned EA_BIT         = 7;
    localparam logic [7:0]  VEC_BASE_DEF   = 8'h03;
    localparam int unsigned VEC_STRIDE_DEF = 8;
    localparam logic [N_SRC_DEF-1:0] HW_CLR_MASK_DEF = 5'b01111;

    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } arb_state_t;

    // Vector address of a source; 8-bit wrap is excluded by the top-level elaboration check.
    function automatic logic [7:0] vec_addr(input logic [7:0] base,
                                            input int unsigned stride,
                                            input int unsigned idx);
        return 8'(32'(base) + stride * idx);
    endfunction

endpackage

// File: rtl/interrupt_arbiter_if.sv
// Arbiter <-> CPU/peripheral signal bundle; master = arbiter, slave = CPU side.
interface interrupt_arbiter_if #(
    parameter int unsigned N_SRC = 5
);
    logic [N_SRC-1:0] src_req;
    logic [7:0]       ie_reg;
    logic [N_SRC-1:0] ip_reg;
    logic             int_req;
    logic [7:0]       int_vec;
    logic             int_ack;
    logic             reti;
    logic [N_SRC-1:0] clr_flag;
    logic [1:0]       in_service;

    modport master (
        input  src_req, ie_reg, ip_reg, int_ack, reti,
        output int_req, int_vec, clr_flag, in_service
    );

    modport slave (
        output src_req, ie_reg, ip_reg, int_ack, reti,
        input  int_req, int_vec, clr_flag, in_service
    );
endinterface

// File: rtl/int_prio_enc.sv
// Two-level priority encoder: high level beats low, lowest index wins within a level,
// and the in-service state decides which levels may be granted at all.
module int_prio_enc import int_pkg::*; #(
    parameter int unsigned N_SRC = N_SRC_DEF,
    parameter int unsigned IDX_W = 3
) (
    input  logic [N_SRC-1:0] i_pending,
    input  logic [N_SRC-1:0] i_ip,
    input  logic [1:0]       i_in_service,
    output logic             o_valid_c,
    output logic [IDX_W-1:0] o_sel_idx_c,
    output logic             o_sel_lvl_c
);

    logic [N_SRC-1:0] w_hi;
    logic [N_SRC-1:0] w_lo;
    logic [IDX_W-1:0] w_hi_idx;
    logic [IDX_W-1:0] w_lo_idx;

    // Scanning downward leaves the lowest set index in each result.
    always_comb begin
        w_hi     = i_pending & i_ip;
        w_lo     = i_pending & ~i_ip;
        w_hi_idx = '0;
        w_lo_idx = '0;
        for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
            if (w_hi[i]) w_hi_idx = IDX_W'(i);
            if (w_lo[i]) w_lo_idx = IDX_W'(i);
        end
    end

    always_comb begin
        o_sel_lvl_c = |w_hi;
        o_sel_idx_c = o_sel_lvl_c ? w_hi_idx : w_lo_idx;
        if (i_in_service[1])
            o_valid_c = 1'b0;
        else if (i_in_service[0])
            o_valid_c = |w_hi;
        else
            o_valid_c = |i_pending;
    end

endmodule

// File: rtl/interrupt_arbiter.sv
// 8051 interrupt arbiter: masks sources with IE/IP, latches one winner into a req/ack
// handshake with the CPU sequencer and tracks two-level in-service nesting until RETI.
module interrupt_arbiter import int_pkg::*; #(
    parameter int unsigned      N_SRC       = N_SRC_DEF,
    parameter logic [7:0]       VEC_BASE    = VEC_BASE_DEF,
    parameter int unsigned      VEC_STRIDE  = VEC_STRIDE_DEF,
    parameter logic [N_SRC-1:0] HW_CLR_MASK = N_SRC'(HW_CLR_MASK_DEF)
) (
    input  logic                  clock,
    input  logic                  reset,
    interrupt_arbiter_if.master   bus
);

    localparam int unsigned IDX_W    = (N_SRC > 1) ? $clog2(N_SRC) : 1;
    localparam int unsigned VEC_LAST = 32'(VEC_BASE) + VEC_STRIDE * (N_SRC - 1);

    if (VEC_LAST > 32'd255) begin : g_vec_overflow
        $error("interrupt_arbiter: highest vector address exceeds 8 bits");
    end
    if (N_SRC > EA_BIT) begin : g_src_overlap
        $error("interrupt_arbiter: N_SRC overlaps the EA bit of IE");
    end

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    logic             r_int_req;
    logic             w_int_req_nxt;
    logic [7:0]       r_int_vec;
    logic [7:0]       w_int_vec_nxt;
    logic [N_SRC-1:0] r_clr_flag;
    logic [N_SRC-1:0] w_clr_flag_nxt;
    logic [1:0]       r_in_service;
    logic [1:0]       w_in_service_nxt;
    logic [IDX_W-1:0] r_sel_idx;
    logic [IDX_W-1:0] w_sel_idx_nxt;
    logic             r_sel_lvl;
    logic             w_sel_lvl_nxt;

    logic [N_SRC-1:0] w_pending;
    logic             w_sel_pending;
    logic             w_valid;
    logic [IDX_W-1:0] w_sel_idx;
    logic             w_sel_lvl;
    logic             w_unused_ie;

    assign w_pending     = bus.src_req & bus.ie_reg[N_SRC-1:0] & {N_SRC{bus.ie_reg[EA_BIT]}};
    assign w_sel_pending = w_pending[r_sel_idx];
    assign w_unused_ie   = ^bus.ie_reg;

    int_prio_enc #(
        .N_SRC (N_SRC),
        .IDX_W (IDX_W)
    ) u_prio_enc (
        .i_pending    (w_pending),
        .i_ip         (bus.ip_reg),
        .i_in_service (r_in_service),
        .o_valid_c    (w_valid),
        .o_sel_idx_c  (w_sel_idx),
        .o_sel_lvl_c  (w_sel_lvl)
    );

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= IDLE;
            r_int_req    <= 1'b0;
            r_int_vec    <= 8'h00;
            r_clr_flag   <= '0;
            r_in_service <= 2'b00;
            r_sel_idx    <= '0;
            r_sel_lvl    <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_int_req    <= w_int_req_nxt;
            r_int_vec    <= w_int_vec_nxt;
            r_clr_flag   <= w_clr_flag_nxt;
            r_in_service <= w_in_service_nxt;
            r_sel_idx    <= w_sel_idx_nxt;
            r_sel_lvl    <= w_sel_lvl_nxt;
        end
    end

    // A latched request leaves REQ only on acknowledge or when its own source is withdrawn.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_valid) w_state_nxt = REQ;
            REQ:     if (bus.int_ack || !w_sel_pending) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // RETI clears against the old nesting state before an acknowledge in the same cycle sets.
    always_comb begin
        w_int_req_nxt    = r_int_req;
        w_int_vec_nxt    = r_int_vec;
        w_sel_idx_nxt    = r_sel_idx;
        w_sel_lvl_nxt    = r_sel_lvl;
        w_clr_flag_nxt   = '0;
        w_in_service_nxt = r_in_service;

        if (bus.reti) begin
            if (r_in_service[1])
                w_in_service_nxt[1] = 1'b0;
            else
                w_in_service_nxt[0] = 1'b0;
        end

        unique case (r_state)
            IDLE: begin
                if (w_valid) begin
                    w_int_req_nxt = 1'b1;
                    w_sel_idx_nxt = w_sel_idx;
                    w_sel_lvl_nxt = w_sel_lvl;
                    w_int_vec_nxt = vec_addr(VEC_BASE, VEC_STRIDE, 32'(w_sel_idx));
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    w_int_req_nxt                = 1'b0;
                    w_in_service_nxt[r_sel_lvl]  = 1'b1;
                    w_clr_flag_nxt[r_sel_idx]    = HW_CLR_MASK[r_sel_idx];
                end else if (!w_sel_pending) begin
                    w_int_req_nxt = 1'b0;
                end
            end
            default: w_int_req_nxt = 1'b0;
        endcase
    end

    assign bus.int_req    = r_int_req;
    assign bus.int_vec    = r_int_vec;
    assign bus.clr_flag   = r_clr_flag;
    assign bus.in_service = r_in_service;

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Self-checking bench for interrupt_arbiter: directed scenarios with literal expectations
// plus randomized traffic compared every cycle against a behavioural model.
module tb_interrupt_arbiter;

    localparam int NS = 5;

    logic clock = 1'b0;
    logic reset = 1'b1;

    interrupt_arbiter_if #(.N_SRC(NS)) bus ();

    interrupt_arbiter #(.N_SRC(NS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: a latched request plus a set of active priority levels.
    bit       m_req = 1'b0;
    bit [7:0] m_vec = 8'h00;
    int       m_idx = 0;
    bit       m_lvl = 1'b0;
    bit [4:0] m_clr = 5'b0;
    bit       m_hi_act = 1'b0;
    bit       m_lo_act = 1'b0;
    bit [4:0] mdl_pend;
    bit       mdl_hi0, mdl_lo0, mdl_open, mdl_wlvl;
    int       mdl_win;
    bit [4:0] hw_clear = 5'b01111;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_req = 0; m_vec = 0; m_idx = 0; m_lvl = 0; m_clr = 0;
            m_hi_act = 0; m_lo_act = 0;
        end else begin
            mdl_pend = bus.src_req & bus.ie_reg[4:0] & {5{bus.ie_reg[7]}};
            mdl_hi0  = m_hi_act;
            mdl_lo0  = m_lo_act;
            m_clr    = 5'b0;
            if (bus.reti) begin
                if (m_hi_act) m_hi_act = 0;
                else          m_lo_act = 0;
            end
            if (m_req) begin
                if (bus.int_ack) begin
                    if (m_lvl) m_hi_act = 1; else m_lo_act = 1;
                    m_clr[m_idx] = hw_clear[m_idx];
                    m_req = 0;
                end else if (!mdl_pend[m_idx]) begin
                    m_req = 0;
                end
            end else begin
                mdl_win  = -1;
                mdl_wlvl = 0;
                for (int lv = 1; lv >= 0; lv--) begin
                    mdl_open = (lv == 1) ? !mdl_hi0 : (!mdl_hi0 && !mdl_lo0);
                    for (int i = 0; i < 5; i++) begin
                        if (mdl_win < 0 && mdl_open && mdl_pend[i] && bus.ip_reg[i] == lv[0]) begin
                            mdl_win  = i;
                            mdl_wlvl = lv[0];
                        end
                    end
                end
                if (mdl_win >= 0) begin
                    m_req = 1;
                    m_idx = mdl_win;
                    m_lvl = mdl_wlvl;
                    m_vec = 8'(3 + 8 * mdl_win);
                end
            end
        end
    end

    always @(negedge clock) begin
        chk("int_req", 32'(bus.int_req), 32'(m_req));
        chk("in_service", 32'(bus.in_service), 32'({m_hi_act, m_lo_act}));
        chk("clr_flag", 32'(bus.clr_flag), 32'(m_clr));
        if (m_req || !reset)
            chk("int_vec", 32'(bus.int_vec), 32'(m_vec));
    end

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive_random();
        bit [4:0] s;
        s = bus.src_req & ~m_clr;
        for (int i = 0; i < 5; i++) begin
            if ($urandom_range(0, 7) == 0)       s[i] = 1'b1;
            else if ($urandom_range(0, 31) == 0) s[i] = 1'b0;
        end
        bus.src_req = s;
        if ($urandom_range(0, 19) == 0)
            bus.ie_reg = {($urandom_range(0, 7) != 0), 2'b00, 5'($urandom)};
        if ($urandom_range(0, 29) == 0)
            bus.ip_reg = 5'($urandom);
        bus.int_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
        bus.reti    = ($urandom_range(0, 5) == 0);
    endtask

    initial begin
        bus.src_req = '0; bus.ie_reg = 8'h00; bus.ip_reg = '0;
        bus.int_ack = 1'b0; bus.reti = 1'b0;
        #1 reset = 1'b0;
        @(negedge clock);
        tick();
        chk("rst_req", 32'(bus.int_req), 32'h0);
        chk("rst_vec", 32'(bus.int_vec), 32'h00);
        chk("rst_clr", 32'(bus.clr_flag), 32'h0);
        chk("rst_is", 32'(bus.in_service), 32'h0);

        // release with IE0 pending
        bus.src_req = 5'b00001; bus.ie_reg = 8'h81;
        tick();
        chk("rst_hold_req", 32'(bus.int_req), 32'h0);
        reset = 1'b1;
        tick();
        chk("rel_req", 32'(bus.int_req), 32'h1);
        chk("rel_vec", 32'(bus.int_vec), 32'h03);
        bus.int_ack = 1; bus.src_req = 5'b0; tick(); bus.int_ack = 0;
        chk("rel_clr", 32'(bus.clr_flag), 32'h01);
        chk("rel_is", 32'(bus.in_service), 32'h1);
        bus.reti = 1; tick(); bus.reti = 0;
        chk("rel_reti_is", 32'(bus.in_service), 32'h0);

        // priority: TF1 high beats TF0 low
        bus.src_req = 5'b01010; bus.ie_reg = 8'h8F; bus.ip_reg = 5'b01000;
        tick();
        chk("pri_req", 32'(bus.int_req), 32'h1);
        chk("pri_vec", 32'(bus.int_vec), 32'h1B);
        bus.int_ack = 1; bus.src_req = 5'b00010; tick(); bus.int_ack = 0;
        chk("pri_clr", 32'(bus.clr_flag), 32'h08);
        chk("pri_is", 32'(bus.in_service), 32'h2);
        tick();
        chk("pri_block", 32'(bus.int_req), 32'h0);
        bus.reti = 1; tick(); bus.reti = 0;
        chk("pri_reti_is", 32'(bus.in_service), 32'h0);
        chk("pri_reti_req", 32'(bus.int_req), 32'h0);
        tick();
        chk("tf0_req", 32'(bus.int_req), 32'h1);
        chk("tf0_vec", 32'(bus.int_vec), 32'h0B);

        // nesting: TF0 low, then IE1 high
        bus.int_ack = 1; bus.src_req = 5'b0; tick(); bus.int_ack = 0;
        chk("nest_is1", 32'(bus.in_service), 32'h1);
        chk("nest_clr1", 32'(bus.clr_flag), 32'h02);
        bus.src_req = 5'b00100; bus.ip_reg = 5'b00100;
        tick();
        chk("nest_vec", 32'(bus.int_vec), 32'h13);
        bus.int_ack = 1; bus.src_req = 5'b0; tick(); bus.int_ack = 0;
        chk("nest_is2", 32'(bus.in_service), 32'h3);
        chk("nest_clr2", 32'(bus.clr_flag), 32'h04);
        bus.reti = 1; tick(); bus.reti = 0;
        chk("nest_reti1", 32'(bus.in_service), 32'h1);
        bus.reti = 1; tick(); bus.reti = 0;
        chk("nest_reti2", 32'(bus.in_service), 32'h0);

        // blocking: low in service holds off another low source until RETI
        bus.ip_reg = 5'b0; bus.src_req = 5'b00010; tick();
        bus.int_ack = 1; bus.src_req = 5'b0; tick(); bus.int_ack = 0;
        chk("blk_is", 32'(bus.in_service), 32'h1);
        bus.src_req = 5'b00001;
        tick(); chk("blk_req0", 32'(bus.int_req), 32'h0);
        tick(); chk("blk_req1", 32'(bus.int_req), 32'h0);
        bus.reti = 1; tick(); bus.reti = 0;
        chk("blk_req2", 32'(bus.int_req), 32'h0);
        tick();
        chk("blk_req3", 32'(bus.int_req), 32'h1);
        chk("blk_vec", 32'(bus.int_vec), 32'h03);
        bus.src_req = 5'b0; tick();
        chk("blk_wd", 32'(bus.int_req), 32'h0);

        // withdrawal of TF0 before acknowledge
        bus.src_req = 5'b00010; tick();
        chk("wd_req", 32'(bus.int_req), 32'h1);
        chk("wd_vec", 32'(bus.int_vec), 32'h0B);
        bus.src_req = 5'b0; tick();
        chk("wd_drop", 32'(bus.int_req), 32'h0);
        chk("wd_clr", 32'(bus.clr_flag), 32'h0);
        tick();
        chk("wd_idle", 32'(bus.int_req), 32'h0);

        // same-cycle RETI and acknowledge
        bus.src_req = 5'b00001; tick();
        bus.int_ack = 1; bus.src_req = 5'b0; tick(); bus.int_ack = 0;
        chk("sc_is0", 32'(bus.in_service), 32'h1);
        bus.src_req = 5'b00100; bus.ip_reg = 5'b00100; tick();
        chk("sc_vec", 32'(bus.int_vec), 32'h13);
        bus.int_ack = 1; bus.reti = 1; bus.src_req = 5'b0; tick();
        bus.int_ack = 0; bus.reti = 0;
        chk("sc_is", 32'(bus.in_service), 32'h2);
        chk("sc_clr", 32'(bus.clr_flag), 32'h04);
        bus.reti = 1; tick(); bus.reti = 0;
        chk("sc_is_end", 32'(bus.in_service), 32'h0);

        // serial source: no hardware flag clear
        bus.ip_reg = 5'b0; bus.ie_reg = 8'h90; bus.src_req = 5'b10000; tick();
        chk("ser_req", 32'(bus.int_req), 32'h1);
        chk("ser_vec", 32'(bus.int_vec), 32'h23);
        bus.int_ack = 1; tick(); bus.int_ack = 0;
        chk("ser_clr", 32'(bus.clr_flag), 32'h0);
        chk("ser_is", 32'(bus.in_service), 32'h1);
        bus.src_req = 5'b0; bus.reti = 1; tick(); bus.reti = 0;
        chk("ser_is_end", 32'(bus.in_service), 32'h0);

        // acknowledge in IDLE is ignored
        bus.int_ack = 1; tick(); bus.int_ack = 0;
        chk("idle_ack_is", 32'(bus.in_service), 32'h0);
        chk("idle_ack_clr", 32'(bus.clr_flag), 32'h0);

        // EA cleared during REQ withdraws
        bus.ie_reg = 8'h81; bus.src_req = 5'b00001; tick();
        chk("ea_req", 32'(bus.int_req), 32'h1);
        bus.ie_reg = 8'h01; tick();
        chk("ea_drop", 32'(bus.int_req), 32'h0);
        chk("ea_clr", 32'(bus.clr_flag), 32'h0);

        // reset in the middle of a handshake
        bus.ie_reg = 8'h81; tick();
        chk("mid_req", 32'(bus.int_req), 32'h1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_req", 32'(bus.int_req), 32'h0);
        chk("mid_rst_clr", 32'(bus.clr_flag), 32'h0);
        @(negedge clock);
        bus.int_ack = 1; tick(); bus.int_ack = 0;
        chk("mid_rst_is", 32'(bus.in_service), 32'h0);
        bus.src_req = 5'b0; reset = 1'b1; tick();
        chk("mid_rel_req", 32'(bus.int_req), 32'h0);

        // randomized traffic, checked by the per-cycle compare process
        bus.ie_reg = 8'h9F;
        for (int c = 0; c < 4000; c++) begin
            drive_random();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
